// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one memory port between NUM_PORTS requesting masters (port 0 =
//   dmem, port 1 = imem, further ports for DMA/debug). A winner is picked in
//   IDLE. Its address, write enable and write data are latched and held on the
//   memory bus until mem_ready, or until the optional wait timeout expires. The
//   result is then handed back to the winning port for one cycle.
//   RR_MODE = 0 grants the lowest requesting index. RR_MODE = 1 searches
//   round-robin, starting one past the previous winner.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   req/we [NUM_PORTS]     per-port request (held until ready) and write enable
//   addr, wdata            per-port address/write data, port i at [i*W +: W]
//   gnt                    one-hot owner of the transaction in flight
//   ready                  one-cycle completion pulse to the owner
//   err                    qualifies ready: transaction ended by timeout
//   rdata                  read data while ready is high, else 0
//   mem_req/addr/we/wdata  latched memory bus transaction
//   mem_rdata, mem_ready   memory response, honoured only while BUSY
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RR_MODE    = 0,
    parameter int TIMEOUT    = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS-1:0]            we,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
    output logic [NUM_PORTS-1:0]            gnt,
    output logic [NUM_PORTS-1:0]            ready,
    output logic                            err,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            mem_req,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic                            mem_we,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_ready
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] wait_cnt;

    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [IDX_W-1:0] search_base;
    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand;

    logic [ADDR_WIDTH-1:0] port_addr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] port_wdata [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign port_addr[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign port_wdata[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Pointer advance with wrap. NUM_PORTS need not be a power of two.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_PORTS - 1))
            return '0;
        else
            return i + 1'b1;
    endfunction

    // Winner search. Fixed mode always starts at port 0. Round-robin starts at
    // rr_ptr. The candidate index is reduced modulo NUM_PORTS with one
    // conditional subtract (base and offset are both < NUM_PORTS), so it never
    // leaves the valid port range.
    always_comb begin
        search_base = (RR_MODE != 0) ? rr_ptr : '0;
        win_found   = 1'b0;
        win_idx     = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand_sum = {1'b0, search_base} + (IDX_W+1)'(k);
            if (cand_sum >= (IDX_W+1)'(NUM_PORTS))
                cand_sum = cand_sum - (IDX_W+1)'(NUM_PORTS);
            cand = cand_sum[IDX_W-1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            wait_cnt  <= '0;
            gnt       <= '0;
            ready     <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                // ---- IDLE: arbitrate and latch the winning transaction ----
                S_IDLE: begin
                    if (win_found) begin
                        gnt       <= NUM_PORTS'(1) << win_idx;
                        mem_req   <= 1'b1;
                        mem_addr  <= port_addr[win_idx];
                        mem_we    <= we[win_idx];
                        mem_wdata <= port_wdata[win_idx];
                        wait_cnt  <= '0;
                        if (RR_MODE != 0)
                            rr_ptr <= wrap_inc(win_idx);
                        state     <= S_BUSY;
                    end
                end

                // ---- BUSY: hold the bus until memory answers or time runs out ----
                S_BUSY: begin
                    if (mem_ready) begin
                        rdata   <= mem_rdata;
                        err     <= 1'b0;
                        mem_req <= 1'b0;
                        ready   <= gnt;
                        state   <= S_RESP;
                    end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
                        rdata   <= '0;
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        ready   <= gnt;
                        state   <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                // ---- RESP: single-cycle result to the owner ----
                S_RESP: begin
                    ready <= '0;
                    gnt   <= '0;
                    rdata <= '0;
                    err   <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Two arbiters on one clock and one reset:
//     inst 0: NUM_PORTS=2, fixed priority, TIMEOUT=4
//     inst 1: NUM_PORTS=3, round-robin,    TIMEOUT=4
//   A transaction-level model predicts every output. The model tracks who owns
//   the bus, when the grant was given and whether the result is being
//   returned. A compare process checks both instances on every falling edge.
//   Directed scenarios add literal expectations, then random traffic follows.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // stimulus, indexed [instance][port]
    logic        s_req   [2][3];
    logic [31:0] s_addr  [2][3];
    logic        s_we    [2][3];
    logic [31:0] s_wdata [2][3];
    logic        s_mrdy  [2];
    logic [31:0] s_mrdata[2];

    // observed outputs, indexed [instance]
    logic [1:0]  gnt_a, ready_a;
    logic [2:0]  o_gnt   [2];
    logic [2:0]  o_ready [2];
    logic        o_err   [2];
    logic [31:0] o_rdata [2];
    logic        o_mreq  [2];
    logic [31:0] o_maddr [2];
    logic        o_mwe   [2];
    logic [31:0] o_mwdata[2];

    assign o_gnt[0]   = {1'b0, gnt_a};
    assign o_ready[0] = {1'b0, ready_a};

    mem_bus_arbiter #(
        .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(0), .TIMEOUT(TO)
    ) u_fixed (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({s_req[0][1], s_req[0][0]}),
        .addr      ({s_addr[0][1], s_addr[0][0]}),
        .we        ({s_we[0][1], s_we[0][0]}),
        .wdata     ({s_wdata[0][1], s_wdata[0][0]}),
        .gnt       (gnt_a),
        .ready     (ready_a),
        .err       (o_err[0]),
        .rdata     (o_rdata[0]),
        .mem_req   (o_mreq[0]),
        .mem_addr  (o_maddr[0]),
        .mem_we    (o_mwe[0]),
        .mem_wdata (o_mwdata[0]),
        .mem_rdata (s_mrdata[0]),
        .mem_ready (s_mrdy[0])
    );

    mem_bus_arbiter #(
        .NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1), .TIMEOUT(TO)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({s_req[1][2], s_req[1][1], s_req[1][0]}),
        .addr      ({s_addr[1][2], s_addr[1][1], s_addr[1][0]}),
        .we        ({s_we[1][2], s_we[1][1], s_we[1][0]}),
        .wdata     ({s_wdata[1][2], s_wdata[1][1], s_wdata[1][0]}),
        .gnt       (o_gnt[1]),
        .ready     (o_ready[1]),
        .err       (o_err[1]),
        .rdata     (o_rdata[1]),
        .mem_req   (o_mreq[1]),
        .mem_addr  (o_maddr[1]),
        .mem_we    (o_mwe[1]),
        .mem_wdata (o_mwdata[1]),
        .mem_rdata (s_mrdata[1]),
        .mem_ready (s_mrdy[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // ---- reference model: transaction view of each arbiter ----
    int          np [2] = '{2, 3};
    bit          rr [2] = '{1'b0, 1'b1};
    int          m_owner[2];   // -1: bus free
    bit          m_resp [2];   // result being returned this cycle
    int          m_tg   [2];   // cycle number of the grant
    int          m_ptr  [2];   // round-robin start port
    logic [31:0] m_addr [2];
    logic        m_we   [2];
    logic [31:0] m_wdata[2];
    logic [31:0] m_rdata[2];
    logic        m_err  [2];

    logic [2:0]  gq[$];

    task automatic chk(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at cycle %0d: got %0h expected %0h",
                     name, inst, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1;
            m_resp[i]  = 1'b0;
            m_tg[i]    = 0;
            m_ptr[i]   = 0;
            m_addr[i]  = '0;
            m_we[i]    = 1'b0;
            m_wdata[i] = '0;
            m_rdata[i] = '0;
            m_err[i]   = 1'b0;
        end
    endtask

    task automatic model_update(input int i);
        int w;
        int p;
        if (m_owner[i] < 0) begin
            w = -1;
            for (int k = 0; k < np[i]; k++) begin
                p = rr[i] ? (m_ptr[i] + k) % np[i] : k;
                if (w < 0 && s_req[i][p]) w = p;
            end
            if (w >= 0) begin
                m_owner[i] = w;
                m_tg[i]    = cyc;
                m_addr[i]  = s_addr[i][w];
                m_we[i]    = s_we[i][w];
                m_wdata[i] = s_wdata[i][w];
                if (rr[i]) m_ptr[i] = (w + 1) % np[i];
            end
        end else if (!m_resp[i]) begin
            if (s_mrdy[i]) begin
                m_resp[i]  = 1'b1;
                m_rdata[i] = s_mrdata[i];
                m_err[i]   = 1'b0;
            end else if (cyc - m_tg[i] == TO) begin
                m_resp[i]  = 1'b1;
                m_rdata[i] = '0;
                m_err[i]   = 1'b1;
            end
        end else begin
            m_owner[i] = -1;
            m_resp[i]  = 1'b0;
        end
    endtask

    task automatic compare(input int i);
        logic [2:0] eg;
        bit         on_bus;
        eg     = (m_owner[i] >= 0) ? 3'(1 << m_owner[i]) : 3'b000;
        on_bus = (m_owner[i] >= 0) && !m_resp[i];
        chk("gnt",     i, o_gnt[i],   eg);
        chk("ready",   i, o_ready[i], m_resp[i] ? eg : 3'b000);
        chk("err",     i, o_err[i],   m_resp[i] & m_err[i]);
        chk("rdata",   i, o_rdata[i], m_resp[i] ? m_rdata[i] : 32'h0);
        chk("mem_req", i, o_mreq[i],  on_bus);
        if (on_bus) begin
            chk("mem_addr",  i, o_maddr[i],  m_addr[i]);
            chk("mem_we",    i, o_mwe[i],    m_we[i]);
            chk("mem_wdata", i, o_mwdata[i], m_wdata[i]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare(0);
            compare(1);
        end
    end

    // One clock: model advances on the edge, inputs may change 1 time unit later.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            model_update(0);
            model_update(1);
        end
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 3; p++) begin
                s_req[i][p]   = 1'b0;
                s_addr[i][p]  = '0;
                s_we[i][p]    = 1'b0;
                s_wdata[i][p] = '0;
            end
            s_mrdy[i]   = 1'b0;
            s_mrdata[i] = '0;
        end
    endtask

    // Records the gnt vector of every transaction starting within ncyc clocks.
    task automatic collect(input int i, input int ncyc, input bit drop);
        logic prev;
        gq.delete();
        for (int c = 0; c < ncyc; c++) begin
            prev = o_mreq[i];
            step();
            if (o_mreq[i] && !prev) gq.push_back(o_gnt[i]);
            if (drop)
                for (int p = 0; p < 3; p++)
                    if (o_ready[i][p]) s_req[i][p] = 1'b0;
        end
    endtask

    initial begin
        logic [2:0] exp3 [6];
        exp3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        clear_inputs();
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_en = 1'b1;
        chk("rst_gnt",     0, o_gnt[0],    0);
        chk("rst_mem_req", 0, o_mreq[0],   0);
        chk("rst_addr",    0, o_maddr[0],  0);
        chk("rst_wdata",   0, o_mwdata[0], 0);
        chk("rst_ready",   1, o_ready[1],  0);
        chk("rst_rdata",   1, o_rdata[1],  0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // single read on port 1, memory answers two cycles after mem_req
        s_req[0][1]  = 1'b1;
        s_addr[0][1] = 32'h100;
        step();
        chk("t1_gnt",  0, o_gnt[0],   3'b010);
        chk("t1_addr", 0, o_maddr[0], 32'h100);
        step();
        s_mrdy[0]   = 1'b1;
        s_mrdata[0] = 32'hDEAD_BEEF;
        step();
        chk("t1_ready", 0, o_ready[0], 3'b010);
        chk("t1_rdata", 0, o_rdata[0], 32'hDEAD_BEEF);
        chk("t1_err",   0, o_err[0],   1'b0);
        s_req[0][1] = 1'b0;
        s_mrdy[0]   = 1'b0;
        step();
        chk("t1_pulse", 0, o_ready[0], 3'b000);

        // fixed priority, both ports at once, each drops req on its ready
        s_req[0][0] = 1'b1;
        s_req[0][1] = 1'b1;
        s_mrdy[0]   = 1'b1;
        collect(0, 8, 1'b1);
        chk("t2_count", 0, gq.size(), 2);
        if (gq.size() == 2) begin
            chk("t2_first",  0, gq[0], 3'b001);
            chk("t2_second", 0, gq[1], 3'b010);
        end
        clear_inputs();
        step();

        // timeout: memory never answers
        s_req[0][0] = 1'b1;
        s_mrdata[0] = 32'h1234_5678;
        step();
        for (int k = 1; k < TO; k++) begin
            step();
            chk("t4_wait", 0, o_ready[0], 3'b000);
        end
        step();
        chk("t4_ready", 0, o_ready[0], 3'b001);
        chk("t4_err",   0, o_err[0],   1'b1);
        chk("t4_rdata", 0, o_rdata[0], 32'h0);
        s_req[0][0] = 1'b0;
        step();
        chk("t4_err_clr", 0, o_err[0], 1'b0);

        // write whose inputs change while on the bus; ready lands on the timeout cycle
        s_req[0][0]   = 1'b1;
        s_addr[0][0]  = 32'h40;
        s_wdata[0][0] = 32'h55;
        s_we[0][0]    = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            s_addr[0][0]  = $urandom;
            s_wdata[0][0] = $urandom;
            s_we[0][0]    = 1'b0;
            step();
            chk("t5_addr",  0, o_maddr[0],  32'h40);
            chk("t5_wdata", 0, o_mwdata[0], 32'h55);
            chk("t5_we",    0, o_mwe[0],    1'b1);
        end
        s_mrdy[0]   = 1'b1;
        s_mrdata[0] = 32'hA5A5_0001;
        step();
        chk("t5_ready", 0, o_ready[0], 3'b001);
        chk("t5_err",   0, o_err[0],   1'b0);
        clear_inputs();
        step();

        // round-robin with all three requests held
        s_req[1][0] = 1'b1;
        s_req[1][1] = 1'b1;
        s_req[1][2] = 1'b1;
        s_mrdy[1]   = 1'b1;
        collect(1, 18, 1'b0);
        chk("t3_count", 1, gq.size(), 6);
        for (int k = 0; k < 6 && k < gq.size(); k++)
            chk("t3_order", 1, gq[k], exp3[k]);
        clear_inputs();
        step();

        // reset while busy, then a fresh request
        s_req[1][2] = 1'b1;
        step();
        chk("t6_gnt", 1, o_gnt[1], 3'b100);
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_gnt0",  1, o_gnt[1],  3'b000);
        chk("t6_mreq0", 1, o_mreq[1], 1'b0);
        chk("t6_addr0", 1, o_maddr[1], 32'h0);
        step();
        chk("t6_noready", 1, o_ready[1], 3'b000);
        rst_n       = 1'b1;
        s_req[1][2] = 1'b0;
        s_req[1][1] = 1'b1;
        s_mrdy[1]   = 1'b1;
        s_mrdata[1] = 32'h0BAD_F00D;
        step();
        chk("t6_regnt", 1, o_gnt[1], 3'b010);
        step();
        chk("t6_ready", 1, o_ready[1], 3'b010);
        chk("t6_rdata", 1, o_rdata[1], 32'h0BAD_F00D);
        clear_inputs();
        step();

        // random traffic on both instances
        for (int c = 0; c < 4000; c++) begin
            step();
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                model_reset();
                step();
                rst_n = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < np[i]; p++) begin
                    if (o_ready[i][p] && $urandom_range(0, 99) < 70)
                        s_req[i][p] = 1'b0;
                    else if (!s_req[i][p])
                        s_req[i][p] = ($urandom_range(0, 99) < 30);
                    else if ($urandom_range(0, 99) < 10)
                        s_req[i][p] = 1'b0;
                    s_addr[i][p]  = $urandom;
                    s_wdata[i][p] = $urandom;
                    s_we[i][p]    = $urandom_range(0, 1) == 1;
                end
                s_mrdy[i]   = ($urandom_range(0, 99) < 30);
                s_mrdata[i] = $urandom;
            end
        end
        clear_inputs();
        step();
        step();
        @(posedge clk);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
